// File: rtl/ahb3lite_host_slave.sv
// ahb3lite_host_slave
//   AHB3-lite slave that turns each accepted transfer into a byte request on
//   an outgoing FIFO and completes it from response bytes on an incoming FIFO.
//   One transfer is outstanding at a time.
//
//   Request:  CMD {HWRITE,0,HSIZE[1:0],0000}, 4 address bytes LSB first,
//             then (writes) 1<<HSIZE data bytes LSB first.
//   Response: status byte (0x00 = OK), then (OK reads) 1<<HSIZE data bytes.
//
// Ports
//   CLK, RESETn            clock, async active-low reset
//   HSEL..HREADY           AHB3-lite slave inputs
//   HRDATA, HRESP,         AHB3-lite slave outputs
//   HREADYOUT
//   WREN, WRDATA, WRFULL   TX byte FIFO write side
//   RDEN, RDDATA, RDEMPTY  RX byte FIFO read side (1-cycle read latency)
//   TIMEDOUT               sticky response-timeout flag
//   TIMEOUT (param)        cycles to wait for each RX byte, 0 = never
module ahb3lite_host_slave #(
  parameter int TIMEOUT = 65535
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        HREADYOUT,
  output logic        WREN,
  output logic [7:0]  WRDATA,
  input  logic        WRFULL,
  output logic        RDEN,
  input  logic [7:0]  RDDATA,
  input  logic        RDEMPTY,
  output logic        TIMEDOUT
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RSTAT, S_RDATA, S_DONE, S_ERR1, S_ERR2
  } state_t;

  localparam logic [31:0] TO_LIM = TIMEOUT;

  state_t      state, nxt;
  logic [31:0] addr, wdat, rbuf, rbuf_nx, tcnt;
  logic        wr, first, pend;
  logic [1:0]  size, bcnt, nlast;
  logic        accept, bad, last, tx_st, rx_st, to_hit;
  logic [7:0]  tx_byte;
  logic        unused_htrans;

  assign unused_htrans = HTRANS[0];

  // A new address phase is only taken while the bus sees us ready.
  assign accept = HSEL & HTRANS[1] & HREADY &
                  (state == S_IDLE || state == S_DONE || state == S_ERR2);
  assign bad    = (HSIZE > 3'd2) || (HSIZE == 3'd1 && HADDR[0]) ||
                  (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) || TIMEDOUT;

  // Index of the last data byte: 0, 1 or 3.
  assign nlast = {size[1], |size};
  assign last  = (bcnt == nlast);

  assign tx_st  = (state == S_CMD || state == S_ADDR || state == S_WDATA);
  assign rx_st  = (state == S_RSTAT || state == S_RDATA);
  // Timeout wins over a pop in the same cycle so no byte is stolen from
  // a transfer that is already being abandoned.
  assign to_hit = rx_st && !pend && (TO_LIM != 32'd0) && (tcnt + 32'd1 == TO_LIM);

  // FIFO handshakes are combinational on the flags so a push/pop never
  // acts on a stale full/empty.
  assign WREN   = tx_st && !WRFULL;
  assign WRDATA = WREN ? tx_byte : 8'h00;
  assign RDEN   = rx_st && !pend && !RDEMPTY && !to_hit;

  always_comb begin
    tx_byte = 8'h00;
    case (state)
      S_CMD:   tx_byte = {wr, 1'b0, size, 4'b0000};
      S_ADDR:  tx_byte = addr[{bcnt, 3'b000} +: 8];
      S_WDATA: tx_byte = wdat[{bcnt, 3'b000} +: 8];
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    rbuf_nx = rbuf;
    rbuf_nx[{bcnt, 3'b000} +: 8] = RDDATA;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR2:
        nxt = accept ? (bad ? S_ERR1 : S_CMD) : S_IDLE;
      S_CMD:   if (WREN) nxt = S_ADDR;
      S_ADDR:  if (WREN && bcnt == 2'd3) nxt = wr ? S_WDATA : S_RSTAT;
      S_WDATA: if (WREN && last) nxt = S_RSTAT;
      S_RSTAT: begin
        if (pend)        nxt = (RDDATA != 8'h00) ? S_ERR1 : (wr ? S_DONE : S_RDATA);
        else if (to_hit) nxt = S_ERR1;
      end
      S_RDATA: begin
        if (pend && last) nxt = S_DONE;
        else if (to_hit)  nxt = S_ERR1;
      end
      S_ERR1:  nxt = S_ERR2;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 32'h0;
      TIMEDOUT  <= 1'b0;
      addr      <= 32'h0;
      wr        <= 1'b0;
      size      <= 2'd0;
      wdat      <= 32'h0;
      rbuf      <= 32'h0;
      bcnt      <= 2'd0;
      first     <= 1'b0;
      pend      <= 1'b0;
      tcnt      <= 32'h0;
    end else begin
      state     <= nxt;
      HREADYOUT <= (nxt == S_IDLE || nxt == S_DONE || nxt == S_ERR2);
      HRESP     <= (nxt == S_ERR1 || nxt == S_ERR2);
      pend      <= RDEN;
      first     <= (nxt == S_CMD) && (state != S_CMD);
      // Counts idle wait cycles; a received byte or leaving RX restarts it.
      tcnt      <= (rx_st && !pend) ? tcnt + 32'd1 : 32'h0;
      if (to_hit) TIMEDOUT <= 1'b1;

      if (nxt != state)
        bcnt <= 2'd0;
      else if (((state == S_ADDR || state == S_WDATA) && WREN) ||
               (state == S_RDATA && pend))
        bcnt <= bcnt + 2'd1;

      if (accept) begin
        addr <= HADDR;
        wr   <= HWRITE;
        size <= HSIZE[1:0];
        rbuf <= 32'h0;
      end

      // Align the addressed lane down to byte 0 once, in the first data cycle.
      if (state == S_CMD && first)
        wdat <= HWDATA >> {HADDR_lane(addr), 3'b000};

      if (state == S_RDATA && pend)
        rbuf <= rbuf_nx;

      HRDATA <= (state == S_RDATA && pend && last) ?
                (rbuf_nx << {HADDR_lane(addr), 3'b000}) : 32'h0;
    end
  end

  function automatic logic [1:0] HADDR_lane(input logic [31:0] a);
    return a[1:0];
  endfunction

endmodule

// File: tb/tb_ahb3lite_host_slave.sv
// Self-checking bench for ahb3lite_host_slave: directed test-plan steps plus
// randomized transfers, checked against a transaction-level model of the
// byte protocol (expected TX byte list, response, read data, wait cycles).
module tb_ahb3lite_host_slave;
  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP, HREADYOUT, WREN, WRFULL, RDEN, RDEMPTY, TIMEDOUT;
  logic [7:0]  WRDATA, RDDATA;

  ahb3lite_host_slave #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HRESP(HRESP), .HREADYOUT(HREADYOUT), .WREN(WREN),
    .WRDATA(WRDATA), .WRFULL(WRFULL), .RDEN(RDEN), .RDDATA(RDDATA),
    .RDEMPTY(RDEMPTY), .TIMEDOUT(TIMEDOUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  logic [7:0] txmem [0:1023];
  int tx_cnt = 0;
  logic [7:0] rxmem [0:255];
  int rx_wr = 0, rx_rd = 0, bad_pops = 0;
  logic [7:0] rd_nx = 8'h00;
  int full_mode = 0;
  bit stall_on = 1'b0;
  bit to_model = 1'b0;

  // FIFO-side monitor: records pushed bytes, serves pops from the RX store.
  initial forever begin
    @(negedge CLK);
    if (!RESETn) rx_rd = rx_wr;
    else begin
      if (WREN) begin txmem[tx_cnt % 1024] = WRDATA; tx_cnt++; end
      if (RDEN) begin
        if (rx_rd == rx_wr) bad_pops++;
        else begin rd_nx = rxmem[rx_rd % 256]; rx_rd++; end
      end
    end
  end

  // FIFO flag/data driver, updated just after each rising edge.
  initial begin
    WRFULL = 1'b0; RDEMPTY = 1'b1; RDDATA = 8'h00;
    forever begin
      @(posedge CLK); #1;
      RDDATA = rd_nx;
      case (full_mode)
        1:       WRFULL = ~WRFULL;
        2:       WRFULL = ($urandom_range(0, 2) == 0);
        default: WRFULL = 1'b0;
      endcase
      RDEMPTY = (rx_rd == rx_wr) || (stall_on && $urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rxmem[rx_wr % 256] = b;
    rx_wr++;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ":hreadyout"}, 32'(HREADYOUT), 32'd1);
    chk({tag, ":hresp"},     32'(HRESP),     32'd0);
    chk({tag, ":hrdata"},    HRDATA,         32'd0);
    chk({tag, ":wren"},      32'(WREN),      32'd0);
    chk({tag, ":wrdata"},    32'(WRDATA),    32'd0);
    chk({tag, ":rden"},      32'(RDEN),      32'd0);
    chk({tag, ":timedout"},  32'(TIMEDOUT),  32'd0);
  endtask

  task automatic do_reset();
    HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
    RESETn = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    to_model = 1'b0;
  endtask

  // One AHB transfer starting at a falling edge; returns at the falling edge
  // of the completion cycle.
  task automatic xfer(input logic [31:0] a, input bit w, input logic [2:0] sz,
                      input logic [31:0] wd, output bit resp, output logic [31:0] rdata,
                      output int waits, output bit last_resp, output bit hung);
    waits = 0; last_resp = 1'b0; hung = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz; HREADY = 1'b1;
    @(posedge CLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd; HADDR = $urandom();
    @(negedge CLK);
    while (!HREADYOUT && !hung) begin
      waits++;
      last_resp = HRESP;
      if (waits > 3000) hung = 1'b1;
      else @(negedge CLK);
    end
    resp = HRESP;
    rdata = HRDATA;
  endtask

  // Model: builds the expected byte stream and outcome from the protocol rules.
  task automatic run(input string tag, input logic [31:0] a, input bit w,
                     input logic [2:0] sz, input logic [31:0] wd, input logic [7:0] st,
                     input logic [31:0] rv, input bit expect_to, input int stray,
                     input bit chk_wait);
    int n, exp_w, base, got;
    bit rej, exp_err, resp, last_resp, hung;
    logic [7:0] exq[$];
    logic [31:0] exp_rd, rdata;
    int waits;
    n = (sz <= 3'd2) ? (1 << sz) : 1;
    rej = (sz > 3'd2) || (a % n != 0) || to_model;
    exp_rd = 32'h0;
    if (!rej) begin
      exq.push_back({w, 1'b0, sz[1:0], 4'b0000});
      for (int i = 0; i < 4; i++) exq.push_back(8'(a >> (8 * i)));
      if (w) for (int i = 0; i < n; i++) exq.push_back(8'(wd >> (8 * ((a % 4) + i))));
      if (!expect_to) begin
        push_rx(st);
        if (!w && st == 8'h00)
          for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'(rv >> (8 * i));
            push_rx(b);
            exp_rd = exp_rd | (32'(b) << (8 * ((a % 4) + i)));
          end
      end
    end
    for (int i = 0; i < stray; i++) push_rx(8'hEE);
    exp_err = rej || expect_to || (st != 8'h00);
    if (rej)            exp_w = 1;
    else if (expect_to) exp_w = exq.size() + TO + 1;
    else if (st != 0)   exp_w = exq.size() + 3;
    else                exp_w = exq.size() + 2 * (1 + (w ? 0 : n));
    base = tx_cnt;
    xfer(a, w, sz, wd, resp, rdata, waits, last_resp, hung);
    got = tx_cnt - base;
    chk({tag, ":hang"}, 32'(hung), 32'd0);
    chk({tag, ":hresp"}, 32'(resp), 32'(exp_err));
    if (exp_err) chk({tag, ":err1_hresp"}, 32'(last_resp), 32'd1);
    if (!w && !exp_err) chk({tag, ":hrdata"}, rdata, exp_rd);
    chk({tag, ":tx_count"}, 32'(got), 32'(exq.size()));
    for (int i = 0; i < exq.size() && i < got; i++)
      chk({tag, ":tx_byte"}, 32'(txmem[(base + i) % 1024]), 32'(exq[i]));
    chk({tag, ":rx_left"}, 32'(rx_wr - rx_rd), 32'(stray));
    if (expect_to) to_model = 1'b1;
    chk({tag, ":timedout"}, 32'(TIMEDOUT), 32'(to_model));
    if (chk_wait) chk({tag, ":waits"}, 32'(waits), 32'(exp_w));
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    logic [7:0]  st;
    bit          w;
    int          base, k;

    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'd0;
    HWDATA = 32'h0; HREADY = 1'b1; RESETn = 1'b0;
    @(negedge CLK); @(negedge CLK);
    check_reset_vals("reset");
    RESETn = 1'b1;
    @(negedge CLK);

    // Directed test-plan transfers at best-case timing.
    run("wr_word", 32'h2000_0004, 1'b1, 3'd2, 32'h1234_5678, 8'h00, 32'h0, 1'b0, 0, 1'b1);
    run("rd_half", 32'h1000_0002, 1'b0, 3'd1, 32'h0, 8'h00, 32'h0000_ABCD, 1'b0, 0, 1'b1);

    // IDLE transfer with HSEL: zero-wait OKAY, no FIFO traffic.
    base = tx_cnt;
    HSEL = 1'b1; HTRANS = 2'b00;
    @(negedge CLK);
    chk("idle:hreadyout", 32'(HREADYOUT), 32'd1);
    chk("idle:hresp", 32'(HRESP), 32'd0);
    chk("idle:tx", 32'(tx_cnt - base), 32'd0);
    HSEL = 1'b0;

    full_mode = 1;
    run("wr_full_tgl", 32'h4000_0008, 1'b1, 3'd2, 32'hCAFE_F00D, 8'h00, 32'h0, 1'b0, 0, 1'b0);
    full_mode = 0;

    // Randomized transfers with FIFO back-pressure, some back-to-back.
    full_mode = 2; stall_on = 1'b1;
    for (int t = 0; t < 40; t++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a = $urandom();
      if (sz <= 3'd2 && $urandom_range(0, 9) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      w = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run("rnd", a, w, sz, $urandom(), st, $urandom(), 1'b0, 0, 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge CLK);
    end
    full_mode = 0; stall_on = 1'b0;
    @(negedge CLK); @(negedge CLK);

    // Randomized best-case transfers with cycle-exact wait checks.
    for (int t = 0; t < 12; t++) begin
      sz = 3'($urandom_range(0, 2));
      a = $urandom() & ~((32'd1 << sz) - 32'd1);
      w = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run("rnd_bc", a, w, sz, $urandom(), st, $urandom(), 1'b0, 0, 1'b1);
      @(negedge CLK); @(negedge CLK);
    end

    // Status error: two-cycle ERROR, stray byte left unpopped.
    run("st_err", 32'h3000_0001, 1'b1, 3'd0, 32'h0000_AB00, 8'h01, 32'h0, 1'b0, 1, 1'b1);
    do_reset();

    // Timeout, then immediate rejection while TIMEDOUT is set.
    run("tmo", 32'h5000_0000, 1'b0, 3'd2, 32'h0, 8'h00, 32'h0, 1'b1, 0, 1'b1);
    run("after_tmo", 32'h5000_0004, 1'b1, 3'd2, 32'h1122_3344, 8'h00, 32'h0, 1'b0, 0, 1'b1);
    do_reset();
    chk("rst_clears_timedout", 32'(TIMEDOUT), 32'd0);

    // Misaligned word: immediate ERROR, nothing pushed or popped.
    run("misalign", 32'h6000_0001, 1'b1, 3'd2, 32'h5555_AAAA, 8'h00, 32'h0, 1'b0, 1, 1'b1);
    do_reset();

    // Reset asserted while the address bytes are going out.
    base = tx_cnt;
    push_rx(8'h00);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h7000_0010; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge CLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF;
    k = 0;
    while (tx_cnt - base < 2 && k < 100) begin @(negedge CLK); k++; end
    chk("mid:reached_addr", 32'(tx_cnt - base >= 2), 32'd1);
    RESETn = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    @(negedge CLK); @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    to_model = 1'b0;
    run("post_rst", 32'h7000_0020, 1'b0, 3'd0, 32'h0, 8'h00, 32'h0000_005A, 1'b0, 0, 1'b1);

    chk("no_pop_when_empty", 32'(bad_pops), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
